congruence_xform: RTL and testbench

Parametrised sequential engine that computes the symmetric congruence transform R = Eᵀ·M·E, or R = E·M·Eᵀ in transpose mode, on signed fixed-point 3×3 matrices. It is the successor to the fixed-width dual-multiplier E-transpose/M/E stage in the OBB collision pipeline. Work is time-multiplexed through a single three-term dot-product unit, with an explicit start/busy/done handshake. Only the upper triangle of R (six words) is produced; downstream separating-axis logic consumes it.

---
 rtl/obb_pkg.sv | 39 +++
 rtl/congruence_xform_dot3.sv | 39 +++
 rtl/congruence_xform.sv | 156 +++++++++++++++
 tb/tb_congruence_xform.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obb_pkg.sv
// Shared types, step-order tables and narrowing helper for the congruence transform engine.
package obb_pkg;

  typedef enum logic [1:0] {IDLE, P1, P2, DONE} state_e;

  localparam logic [3:0] P1_LEN = 4'd9;
  localparam logic [3:0] P2_LEN = 4'd6;

  // Two bits per step, step 0 at the LSBs.
  localparam logic [17:0] P1_I_TAB = {2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
  localparam logic [17:0] P1_J_TAB = {2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};
  localparam logic [11:0] P2_I_TAB = {2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
  localparam logic [11:0] P2_J_TAB = {2'd2, 2'd2, 2'd1, 2'd2, 2'd1, 2'd0};

  localparam int WIDE = 80;
  typedef logic signed [WIDE-1:0] wide_t;

  function automatic logic [3:0] idx3(input logic [1:0] r, input logic [1:0] c);
    return 4'(r) * 4'd3 + 4'(c);
  endfunction

  function automatic wide_t sat_narrow(input wide_t x, input int unsigned w, output logic clamped);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    clamped = 1'b0;
    if (x > hi) begin
      clamped = 1'b1;
      return hi;
    end
    if (x < lo) begin
      clamped = 1'b1;
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/congruence_xform_dot3.sv
// Combinational three-term signed dot product with FRAC rescale and W-bit narrowing.
// SATURATE_EN selects clamping (with ovf); otherwise the low W bits are kept.
module dot3 import obb_pkg::*; #(
  parameter int W    = 21,
  parameter int FRAC = 8
) (
  input  logic signed [W-1:0] a0,
  input  logic signed [W-1:0] a1,
  input  logic signed [W-1:0] a2,
  input  logic signed [W-1:0] b0,
  input  logic signed [W-1:0] b1,
  input  logic signed [W-1:0] b2,
  output logic signed [W-1:0] y,
  output logic                ovf
);

  logic signed [2*W-1:0] p0, p1, p2;
  logic signed [2*W+1:0] sum;
`ifdef SATURATE_EN
  wide_t yw;
  logic  clamp;
`endif

  always_comb begin
    p0  = a0 * b0;
    p1  = a1 * b1;
    p2  = a2 * b2;
    sum = (2*W+2)'(p0) + (2*W+2)'(p1) + (2*W+2)'(p2);
`ifdef SATURATE_EN
    yw  = sat_narrow(wide_t'(sum >>> FRAC), W, clamp);
    y   = W'(yw);
    ovf = clamp;
`else
    y   = W'(sum >>> FRAC);
    ovf = 1'b0;
`endif
  end

endmodule

// File: rtl/congruence_xform.sv
// Sequential R = E^T*M*E (mode 0) or E*M*E^T (mode 1) engine, upper triangle only.
// Narrowing behaviour follows SATURATE_EN inside dot3; without it ovf stays 0.
module congruence_xform import obb_pkg::*; #(
  parameter int W    = 21,
  parameter int FRAC = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           mode,
  input  logic [9*W-1:0] e_flat,
  input  logic [9*W-1:0] m_flat,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   r11,
  output logic [W-1:0]   r12,
  output logic [W-1:0]   r13,
  output logic [W-1:0]   r22,
  output logic [W-1:0]   r23,
  output logic [W-1:0]   r33,
  output logic           ovf
);

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic mode_q, mode_d;
  logic ovfs_q, ovfs_d, ovf_q, ovf_d, done_q, done_d;
  logic signed [W-1:0] e_q [9];
  logic signed [W-1:0] e_d [9];
  logic signed [W-1:0] m_q [9];
  logic signed [W-1:0] m_d [9];
  logic signed [W-1:0] t_q [9];
  logic signed [W-1:0] t_d [9];
  logic signed [W-1:0] rs_q [6];
  logic signed [W-1:0] rs_d [6];
  logic signed [W-1:0] r_q [6];
  logic signed [W-1:0] r_d [6];

  logic [1:0] op_i, op_j;
  logic signed [W-1:0] a [3];
  logic signed [W-1:0] b [3];
  logic signed [W-1:0] dot_y;
  logic dot_ovf;

  // P1 walks T row-major; P2 walks the upper triangle of R.
  always_comb begin
    op_i = P1_I_TAB[{cnt_q, 1'b0} +: 2];
    op_j = P1_J_TAB[{cnt_q, 1'b0} +: 2];
    for (int k = 0; k < 3; k++) begin
      a[k] = mode_q ? e_q[idx3(op_i, 2'(k))] : e_q[idx3(2'(k), op_i)];
      b[k] = m_q[idx3(2'(k), op_j)];
    end
    if (state_q == P2) begin
      op_i = P2_I_TAB[{cnt_q, 1'b0} +: 2];
      op_j = P2_J_TAB[{cnt_q, 1'b0} +: 2];
      for (int k = 0; k < 3; k++) begin
        a[k] = t_q[idx3(op_i, 2'(k))];
        b[k] = mode_q ? e_q[idx3(op_j, 2'(k))] : e_q[idx3(2'(k), op_j)];
      end
    end
  end

  dot3 #(.W(W), .FRAC(FRAC)) u_dot3 (
    .a0(a[0]), .a1(a[1]), .a2(a[2]),
    .b0(b[0]), .b1(b[1]), .b2(b[2]),
    .y(dot_y), .ovf(dot_ovf)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    ovfs_d  = ovfs_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    e_d     = e_q;
    m_d     = m_q;
    t_d     = t_q;
    rs_d    = rs_q;
    r_d     = r_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = P1;
        cnt_d   = 4'd0;
        mode_d  = mode;
        ovfs_d  = 1'b0;
        for (int i = 0; i < 9; i++) begin
          e_d[i] = e_flat[i*W +: W];
          m_d[i] = m_flat[i*W +: W];
        end
      end
      P1: begin
        t_d[cnt_q] = dot_y;
        ovfs_d     = ovfs_q | dot_ovf;
        cnt_d      = (cnt_q == P1_LEN - 4'd1) ? 4'd0 : cnt_q + 4'd1;
        if (cnt_q == P1_LEN - 4'd1) state_d = P2;
      end
      P2: begin
        rs_d[cnt_q[2:0]] = dot_y;
        ovfs_d           = ovfs_q | dot_ovf;
        cnt_d            = cnt_q + 4'd1;
        if (cnt_q == P2_LEN - 4'd1) state_d = DONE;
      end
      DONE: begin
        r_d     = rs_q;
        ovf_d   = ovfs_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      mode_q  <= 1'b0;
      ovfs_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 9; i++) t_q[i] <= '0;
      for (int i = 0; i < 6; i++) begin
        rs_q[i] <= '0;
        r_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      ovfs_q  <= ovfs_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      t_q     <= t_d;
      rs_q    <= rs_d;
      r_q     <= r_d;
    end
  end

  // Operand latches only change on acceptance, so they need no reset.
  always_ff @(posedge clk) begin
    e_q <= e_d;
    m_q <= m_d;
  end

  assign busy = (state_q != IDLE) || done_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign r11  = r_q[0];
  assign r12  = r_q[1];
  assign r13  = r_q[2];
  assign r22  = r_q[3];
  assign r23  = r_q[4];
  assign r33  = r_q[5];

endmodule

// File: tb/tb_congruence_xform.sv
// Bench for congruence_xform: directed and random jobs against a full-matrix reference model.
module tb_congruence_xform;

  localparam int W    = 21;
  localparam int FRAC = 8;

  logic           clk = 1'b0;
  logic           rst, start, mode;
  logic [9*W-1:0] e_flat, m_flat;
  logic           busy, done, ovf;
  logic [W-1:0]   r11, r12, r13, r22, r23, r33;

  int     checks = 0;
  int     errors = 0;
  int     ev [9];
  int     mv [9];
  longint exp_r [6];
  logic   exp_ovf;

  congruence_xform #(.W(W), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .e_flat(e_flat), .m_flat(m_flat),
    .busy(busy), .done(done),
    .r11(r11), .r12(r12), .r13(r13), .r22(r22), .r23(r23), .r33(r33),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint narrow(input longint x, output logic o);
    longint s;
    s = x >>> FRAC;
    o = 1'b0;
`ifdef SATURATE_EN
    if (s > (64'sd1 <<< (W-1)) - 1) begin
      o = 1'b1;
      return (64'sd1 <<< (W-1)) - 1;
    end
    if (s < -(64'sd1 <<< (W-1))) begin
      o = 1'b1;
      return -(64'sd1 <<< (W-1));
    end
    return s;
`else
    return (s <<< (64-W)) >>> (64-W);
`endif
  endfunction

  // R = A*M*B with A = E^T, B = E (mode 0) or A = E, B = E^T (mode 1).
  task automatic model(input logic md);
    longint am [3][3];
    longint bm [3][3];
    longint mm [3][3];
    longint tm [3][3];
    longint rm [3][3];
    longint acc;
    logic   o, any;
    any = 1'b0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        mm[i][j] = mv[i*3+j];
        am[i][j] = md ? ev[i*3+j] : ev[j*3+i];
        bm[i][j] = md ? ev[j*3+i] : ev[i*3+j];
      end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        acc = 0;
        for (int k = 0; k < 3; k++) acc += am[i][k] * mm[k][j];
        tm[i][j] = narrow(acc, o);
        any |= o;
      end
    for (int i = 0; i < 3; i++)
      for (int j = i; j < 3; j++) begin
        acc = 0;
        for (int k = 0; k < 3; k++) acc += tm[i][k] * bm[k][j];
        rm[i][j] = narrow(acc, o);
        any |= o;
      end
    exp_r   = '{rm[0][0], rm[0][1], rm[0][2], rm[1][1], rm[1][2], rm[2][2]};
    exp_ovf = any;
  endtask

  task automatic pack_inputs();
    for (int i = 0; i < 9; i++) begin
      e_flat[i*W +: W] = ev[i][W-1:0];
      m_flat[i*W +: W] = mv[i][W-1:0];
    end
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < 9; i++) begin
      e_flat[i*W +: W] = W'($urandom);
      m_flat[i*W +: W] = W'($urandom);
    end
    mode = $urandom_range(1);
  endtask

  task automatic check_results(input string tag);
    chk({tag, "_r11"}, longint'($signed(r11)), exp_r[0]);
    chk({tag, "_r12"}, longint'($signed(r12)), exp_r[1]);
    chk({tag, "_r13"}, longint'($signed(r13)), exp_r[2]);
    chk({tag, "_r22"}, longint'($signed(r22)), exp_r[3]);
    chk({tag, "_r23"}, longint'($signed(r23)), exp_r[4]);
    chk({tag, "_r33"}, longint'($signed(r33)), exp_r[5]);
    chk({tag, "_ovf"}, longint'(ovf), longint'(exp_ovf));
  endtask

  task automatic run_job(input logic md, input string tag);
    int   lat;
    logic seen;
    model(md);
    @(negedge clk);
    pack_inputs();
    mode  = md;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble_inputs();
    chk({tag, "_busy_rise"}, longint'(busy), 1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done === 1'b1) seen = 1'b1;
    end
    chk({tag, "_latency"}, lat, 16);
    chk({tag, "_busy_at_done"}, longint'(busy), 1);
    check_results(tag);
    @(posedge clk);
    #1;
    chk({tag, "_done_fall"}, longint'(done), 0);
    chk({tag, "_busy_fall"}, longint'(busy), 0);
  endtask

  function automatic int rnd(input int span);
    return int'($urandom_range(2*span - 1)) - span;
  endfunction

  initial begin
    int ndone, first, second;
    rst    = 1'b1;
    start  = 1'b0;
    mode   = 1'b0;
    e_flat = '0;
    m_flat = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", longint'(busy), 0);
    chk("reset_done", longint'(done), 0);
    chk("reset_ovf", longint'(ovf), 0);
    chk("reset_r11", longint'(r11), 0);
    chk("reset_r33", longint'(r33), 0);
    @(negedge clk);
    rst = 1'b0;

    ev = '{256, 0, 0, 0, 256, 0, 0, 0, 256};
    mv = '{512, 0, 0, 0, 768, 0, 0, 0, 1024};
    run_job(1'b0, "diag");
    ev = '{0, 256, 0, 256, 0, 0, 0, 0, 256};
    mv = '{256, 128, 0, 128, 512, 0, 0, 0, 768};
    run_job(1'b0, "swap");
    ev = '{256, 256, 0, 0, 256, 0, 0, 0, 256};
    mv = '{256, 0, 0, 0, 256, 0, 0, 0, 256};
    run_job(1'b0, "shear_m0");
    run_job(1'b1, "shear_m1");
    ev = '{524288, 0, 0, 0, 524288, 0, 0, 0, 524288};
    mv = '{256000, 0, 0, 0, 256000, 0, 0, 0, 256000};
    run_job(1'b0, "big");
    ev = '{256, 0, 0, 0, 256, 0, 0, 0, 256};
    mv = '{-1, 0, 0, 0, 0, 0, 0, 0, 0};
    run_job(1'b0, "negtrunc");

    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 9; i++) begin
        ev[i] = (n % 3 == 2) ? rnd(1 << 20) : rnd(1024);
        mv[i] = (n % 3 == 2) ? rnd(1 << 20) : rnd(4096);
      end
      run_job(logic'(n % 2), $sformatf("rand%0d", n));
    end

    // Re-pulsed start during a job must be ignored.
    for (int i = 0; i < 9; i++) begin
      ev[i] = rnd(512);
      mv[i] = rnd(2048);
    end
    ev[0] = 300;
    mv[0] = 700;
    model(1'b0);
    @(negedge clk);
    pack_inputs();
    mode  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    first = 0;
    for (int c = 6; c <= 45; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          first = c;
          check_results("repulse");
        end
      end
    end
    chk("repulse_done_count", ndone, 1);
    chk("repulse_done_cycle", first, 16);

    // Reset at edge 8 of a job discards it and clears the outputs.
    @(negedge clk);
    mode  = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_done", longint'(done), 0);
    chk("midrst_r11", longint'(r11), 0);
    chk("midrst_ovf", longint'(ovf), 0);
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    ev = '{256, 256, 0, 0, 256, 0, 0, 0, 256};
    mv = '{256, 0, 0, 0, 256, 0, 0, 0, 256};
    run_job(1'b1, "after_rst");

    // Held start re-triggers every 17 cycles.
    for (int i = 0; i < 9; i++) begin
      ev[i] = rnd(700);
      mv[i] = rnd(3000);
    end
    model(1'b1);
    @(negedge clk);
    pack_inputs();
    mode  = 1'b1;
    start = 1'b1;
    @(posedge clk);
    ndone  = 0;
    first  = 0;
    second = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) first = c;
        if (ndone == 2) begin
          second = c;
          check_results("held");
        end
      end
    end
    chk("held_done_count", ndone, 2);
    chk("held_first", first, 16);
    chk("held_second", second, 33);
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    chk("held_idle_busy", longint'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
